// File: rtl/fifo_reader.sv
// fifo_reader: turns read-button edges into single FIFO pops, latches data, flags underflow.
// Define FIFO_READER_SSEG_EN to build the 4-digit seven-segment display driver.
module fifo_reader #(
  parameter int B            = 8,
  parameter int W            = 3,
  parameter int REFRESH_BITS = 18
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         rd_req,
  input  logic         fifo_empty,
  input  logic [W:0]   fifo_count,
  input  logic [B-1:0] fifo_rdata,
  output logic         fifo_re,
  output logic [B-1:0] rd_data,
  output logic         rd_valid,
  output logic         underflow,
  output logic         busy,
  output logic [3:0]   an,
  output logic [7:0]   sseg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_CAP
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_req_q;
  logic         w_edge;
  logic [B-1:0] r_rd_data;
  logic         r_valid;
  logic         r_uf;

  assign w_edge = rd_req & ~r_req_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_edge && !fifo_empty) w_next = S_POP;
      S_POP:   w_next = S_WAIT;
      S_WAIT:  w_next = S_CAP;
      S_CAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_re = (r_state == S_POP);
    busy    = (r_state != S_IDLE);
  end

  // Data is latched on leaving WAIT so rd_data/rd_valid appear two edges after the request.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_req_q   <= 1'b1;
      r_rd_data <= '0;
      r_valid   <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      r_req_q <= rd_req;
      r_valid <= (r_state == S_WAIT);
      if (r_state == S_WAIT) begin
        r_rd_data <= fifo_rdata;
        r_uf      <= 1'b0;
      end else if (r_state == S_IDLE && w_edge && fifo_empty) begin
        r_uf <= 1'b1;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_valid;
  assign underflow = r_uf;

`ifdef FIFO_READER_SSEG_EN
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [1:0]              w_sel;
  logic [7:0]              w_byte;
  logic [3:0]              w_cnt4;
  logic [3:0]              w_nib;
  logic [7:0]              w_seg;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_refresh <= '0;
    else      r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  end

  assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

  // Zero-extend narrow data/count to the fixed display widths.
  always_comb begin
    w_byte = '0;
    w_cnt4 = '0;
    for (int i = 0; i < 8; i++)
      if (i < B) w_byte[i] = r_rd_data[i];
    for (int i = 0; i < 4; i++)
      if (i < W + 1) w_cnt4[i] = fifo_count[i];
  end

  always_comb begin
    w_nib = 4'h0;
    unique case (w_sel)
      2'd0: w_nib = w_byte[3:0];
      2'd1: w_nib = w_byte[7:4];
      2'd2: w_nib = w_cnt4;
      2'd3: w_nib = 4'hE;
      default: w_nib = 4'h0;
    endcase
    w_seg = hex_seg(w_nib);
    if (w_sel == 2'd3 && !r_uf) w_seg = 8'hFF;
  end

  assign an   = ~(4'b0001 << w_sel);
  assign sseg = w_seg;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^fifo_count;
  assign an           = 4'hF;
  assign sseg         = 8'hFF;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: table vectors plus random traffic against a countdown reference model.
// Display checks follow FIFO_READER_SSEG_EN.
module tb_fifo_reader;
  localparam int RB = 6;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rd_req = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_count = 4'd0;
  logic [7:0] fifo_rdata = 8'd0;
  logic       fifo_re;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       underflow;
  logic       busy;
  logic [3:0] an;
  logic [7:0] sseg;

  fifo_reader #(.B(8), .W(3), .REFRESH_BITS(RB)) dut (
    .clk        (clk),
    .clr        (clr),
    .rd_req     (rd_req),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .underflow  (underflow),
    .busy       (busy),
    .an         (an),
    .sseg       (sseg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] mq[$];
  int         cnt;
  logic       mreq_q;
  logic       m_uf;
  logic [7:0] m_data;
  logic [7:0] m_pend;
  int         ticks;

  logic [7:0] gl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    bit         push;
    logic [7:0] pv;
    bit         req;
    bit         re;
    bit         bsy;
    bit         vld;
    bit         uf;
    logic [7:0] data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_disp();
    logic [3:0] ea;
    logic [7:0] es;
`ifdef FIFO_READER_SSEG_EN
    int sel;
    sel = (ticks >> (RB - 2)) & 3;
    ea  = ~(4'b0001 << sel);
    case (sel)
      0: es = gl[m_data[3:0]];
      1: es = gl[m_data[7:4]];
      2: es = gl[fifo_count];
      default: es = m_uf ? 8'h86 : 8'hFF;
    endcase
`else
    ea = 4'hF;
    es = 8'hFF;
`endif
    chk("an", an, ea);
    chk("sseg", sseg, es);
  endtask

  task automatic check_model();
    chk("fifo_re", fifo_re, (cnt == 3));
    chk("busy", busy, (cnt != 0));
    chk("rd_valid", rd_valid, (cnt == 1));
    chk("underflow", underflow, m_uf);
    chk("rd_data", rd_data, m_data);
  endtask

  task automatic model_reset();
    cnt    = 0;
    mreq_q = 1'b1;
    m_uf   = 1'b0;
    m_data = 8'h00;
    ticks  = 0;
  endtask

  task automatic model_edge();
    bit e;
    e      = rd_req && !mreq_q;
    mreq_q = rd_req;
    ticks++;
    if (cnt == 0) begin
      if (e) begin
        if (mq.size() == 0) m_uf = 1'b1;
        else begin
          cnt    = 3;
          m_pend = mq.pop_front();
        end
      end
    end else begin
      cnt--;
      if (cnt == 1) begin
        m_data = m_pend;
        m_uf   = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit req, input bit push, input logic [7:0] pv, input bit use_model);
    @(negedge clk);
    if (fifo_re && q.size() != 0) fifo_rdata = q.pop_front();
    if (push && q.size() < 8) begin
      q.push_back(pv);
      mq.push_back(pv);
    end
    rd_req     = req;
    fifo_empty = (q.size() == 0);
    fifo_count = 4'(q.size());
    @(posedge clk);
    model_edge();
    #1;
    check_disp();
    if (use_model) check_model();
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 8'hA5, 1, 1, 1, 0, 0, 8'h00};
    tbl[1]  = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00};
    tbl[2]  = '{0, 8'h00, 1, 0, 1, 1, 0, 8'hA5};
    tbl[3]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'hA5};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 0, 0, 8'hA5};
    tbl[5]  = '{0, 8'h00, 1, 0, 0, 0, 1, 8'hA5};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 0, 1, 8'hA5};
    tbl[7]  = '{1, 8'h3C, 1, 1, 1, 0, 1, 8'hA5};
    tbl[8]  = '{0, 8'h00, 0, 0, 1, 0, 1, 8'hA5};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 1, 0, 8'h3C};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 0, 0, 8'h3C};

    // reset with the button held
    #2 clr = 1'b0;
    model_reset();
    #1;
    check_model();
    check_disp();
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].req, tbl[i].push, tbl[i].pv, 0);
      chk($sformatf("v%0d.fifo_re", i), fifo_re, tbl[i].re);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d.rd_valid", i), rd_valid, tbl[i].vld);
      chk($sformatf("v%0d.underflow", i), underflow, tbl[i].uf);
      chk($sformatf("v%0d.rd_data", i), rd_data, tbl[i].data);
    end

    // reset one cycle after the pop strobe: the popped word is lost
    cycle(1, 1, 8'h77, 1);
    chk("mid.fifo_re", fifo_re, 1);
    cycle(0, 0, 8'h00, 1);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.rd_data", rd_data, 8'h00);
    chk("mid.rd_valid", rd_valid, 0);
    check_disp();
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);

    for (int i = 0; i < 500; i++)
      cycle(($urandom % 3) != 0, ($urandom % 4) == 0, 8'($urandom), 1);

    // display walk: last pop 0x5A, occupancy 4
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);
    q.delete();
    mq.delete();
    cycle(0, 1, 8'h5A, 1);
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);
    chk("disp.rd_data", rd_data, 8'h5A);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(i + 1), 1);
    chk("disp.count", fifo_count, 4);
    for (int i = 0; i < 4 * (1 << (RB - 2)); i++) cycle(0, 0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
